// File: rtl/ascon_aead128_pkg.sv
// Shared types for the Ascon-AEAD128 ingress path: block type tag and the
// packed block record that flows from the stream packer to the core.
package ascon_aead128_pkg;

  localparam int unsigned ASCON_BLOCK_BYTES = 16;

  typedef enum logic {
    BLK_AD = 1'b0,
    BLK_DB = 1'b1
  } blk_type_e;

  // "type" is reserved, so the block type field is named btype
  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   nbytes;
    blk_type_e    btype;
    logic         last;
  } ascon_blk_t;

endpackage

// File: rtl/ascon_aead128_axis_packer_if.sv
// Stream ingress and block egress signals of the packer, bundled for port
// connection; slave is the packer side, master the source/core side.
interface ascon_aead128_axis_packer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic                    s_axis_tuser;
  logic                    s_axis_tlast;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [127:0]            blk_data;
  logic [4:0]              blk_nbytes;
  logic                    blk_type;
  logic                    blk_last;
  logic                    blk_valid;
  logic                    blk_ready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    input  blk_ready,
    output s_axis_tready,
    output blk_data, blk_nbytes, blk_type, blk_last, blk_valid
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
    output blk_ready,
    input  s_axis_tready,
    input  blk_data, blk_nbytes, blk_type, blk_last, blk_valid
  );
endinterface

// File: rtl/ascon_sync_fifo.sv
// Single-clock FIFO of arbitrary element type with any DEPTH >= 1, an
// occupancy output and a synchronous clear. Head output is zero when empty.
module ascon_sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       clear,
  input  logic                       push,
  input  T                           wdata,
  input  logic                       pop,
  output T                           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  T              mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push = push && !clear && (level != LW'(DEPTH));
    do_pop  = pop && !clear && (level != '0);
    valid   = (level != '0);
    rdata   = valid ? mem[rptr] : '0;
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
      if (do_pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/ascon_aead128_axis_packer.sv
// AXI4-Stream to Ascon 128-bit block packer: accumulates beats into tagged
// blocks, flags keep/type protocol errors, and queues blocks for the core.
module ascon_aead128_axis_packer
  import ascon_aead128_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       clear,
  ascon_aead128_axis_packer_if.slave bus,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       err_keep
);
  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned B  = 128 / DATA_WIDTH;
  localparam int unsigned IW = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(B - 1);

  function automatic logic [4:0] count_bytes(input logic [KW-1:0] keep);
    logic [4:0] n;
    n = '0;
    for (int unsigned j = 0; j < KW; j++) n = n + 5'(keep[j]);
    return n;
  endfunction

  logic [IW-1:0]         beat_idx;
  logic [127:0]          acc_data;
  logic [4:0]            acc_nbytes;
  blk_type_e             acc_type;
  logic                  ready_en;

  logic [DATA_WIDTH-1:0] beat_masked;
  logic [KW-1:0]         keep_inc;
  logic                  keep_full;
  logic                  keep_thermo;
  logic                  first;
  logic                  at_end;
  logic [4:0]            byte_sum;
  logic                  accept;
  logic                  closing;
  logic                  beat_err;
  ascon_blk_t            blk_in;
  ascon_blk_t            head;
  logic                  head_valid;

  // ready_en keeps tready low throughout reset and for no longer
  assign bus.s_axis_tready = ready_en && (fifo_level != LW'(DEPTH)) && !clear;

  always_comb begin
    beat_masked = '0;
    for (int unsigned j = 0; j < KW; j++)
      beat_masked[j*8 +: 8] = bus.s_axis_tkeep[j] ? bus.s_axis_tdata[j*8 +: 8] : 8'h00;
    keep_inc    = bus.s_axis_tkeep + KW'(1);
    keep_full   = &bus.s_axis_tkeep;
    keep_thermo = ((bus.s_axis_tkeep & keep_inc) == '0);
    first       = (beat_idx == '0);
    at_end      = (beat_idx == LAST_IDX);
    byte_sum    = acc_nbytes + count_bytes(bus.s_axis_tkeep);

    blk_in        = '0;
    blk_in.data   = acc_data;
    blk_in.data[beat_idx*DATA_WIDTH +: DATA_WIDTH] = beat_masked;
    blk_in.nbytes = at_end ? 5'(ASCON_BLOCK_BYTES) : byte_sum;
    blk_in.btype  = first ? blk_type_e'(bus.s_axis_tuser) : acc_type;
    blk_in.last   = bus.s_axis_tlast;

    accept   = bus.s_axis_tvalid && bus.s_axis_tready;
    closing  = accept && (bus.s_axis_tlast || at_end);
    beat_err = accept && ((!bus.s_axis_tlast && !keep_full) ||
                          (bus.s_axis_tlast && !keep_thermo) ||
                          (!first && (blk_type_e'(bus.s_axis_tuser) != acc_type)));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en   <= 1'b0;
      beat_idx   <= '0;
      acc_data   <= '0;
      acc_nbytes <= '0;
      acc_type   <= BLK_AD;
      err_keep   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (clear) begin
        beat_idx   <= '0;
        acc_data   <= '0;
        acc_nbytes <= '0;
        acc_type   <= BLK_AD;
        err_keep   <= 1'b0;
      end else begin
        if (beat_err) err_keep <= 1'b1;
        if (closing) begin
          beat_idx   <= '0;
          acc_data   <= '0;
          acc_nbytes <= '0;
        end else if (accept) begin
          beat_idx   <= beat_idx + IW'(1);
          acc_data   <= blk_in.data;
          acc_nbytes <= byte_sum;
          acc_type   <= blk_in.btype;
        end
      end
    end
  end

  ascon_sync_fifo #(
    .T     (ascon_blk_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (clear),
    .push    (closing),
    .wdata   (blk_in),
    .pop     (bus.blk_ready),
    .rdata   (head),
    .valid   (head_valid),
    .level   (fifo_level)
  );

  assign bus.blk_data   = head.data;
  assign bus.blk_nbytes = head.nbytes;
  assign bus.blk_type   = head.btype;
  assign bus.blk_last   = head.last;
  assign bus.blk_valid  = head_valid;
endmodule
